// File: rtl/pic16_pkg.sv
// ============================================================================
// Module      : pic16_pkg
// Description : INTCON bit positions, interrupt sequencer states and the
//               shared pending-interrupt equation.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pic16_pkg;

    localparam int unsigned GIE_BIT  = 7;
    localparam int unsigned PEIE_BIT = 6;
    localparam int unsigned T0IE_BIT = 5;
    localparam int unsigned INTE_BIT = 4;
    localparam int unsigned RBIE_BIT = 3;
    localparam int unsigned T0IF_BIT = 2;
    localparam int unsigned INTF_BIT = 1;
    localparam int unsigned RBIF_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_e;

    function automatic logic intcon_pending(input logic [7:0] r, input logic pir);
        return (r[T0IE_BIT] & r[T0IF_BIT]) |
               (r[INTE_BIT] & r[INTF_BIT]) |
               (r[RBIE_BIT] & r[RBIF_BIT]) |
               (r[PEIE_BIT] & pir);
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_edge_sync.sv
// ============================================================================
// Module      : int_edge_sync
// Description : RB0/INT pad synchronizer with an INTEDG-selected one-clock
//               edge pulse taken from the last two synchronizer stages.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic int_pin_i,
    input  logic intedg_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   w_rise;
    logic                   w_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], int_pin_i};
        end
    end

    // Edges come from data only, so flipping INTEDG alone cannot fake one.
    assign w_rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign w_fall = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
    assign edge_o = intedg_i ? w_rise : w_fall;

endmodule

`default_nettype wire

// File: rtl/intcon_ctrl.sv
// ============================================================================
// Module      : intcon_ctrl
// Description : INTCON register, flag capture and irq/ack/RETFIE sequencer.
//               Define INTCON_RB_CHANGE_EN to build the RB7:RB4 change logic.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module intcon_ctrl
    import pic16_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [12:0] INT_VECTOR  = 13'h004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc_en,
    input  logic        intcon_wr_en,
    input  logic [7:0]  intcon_reg_in,
    output logic [7:0]  intcon_reg_out,
    input  logic        tmr0if_set_en,
    input  logic        int_pin,
    input  logic        intedg,
    input  logic [3:0]  rb_hi,
    input  logic        portb_rd_en,
    input  logic        pir_pending,
    input  logic        int_ack,
    input  logic        retfie,
    output logic        irq,
    output logic [12:0] vector_addr,
    output logic        wake
);

    logic       w_int_edge;
    logic       w_rb_set;
    logic       w_ack;
    logic       w_pend_q;
    logic       w_pend_d;
    logic [7:0] intcon_q, intcon_d;
    logic       t0_pend_q, t0_pend_d;
    logic       int_pend_q, int_pend_d;
    irq_state_e state_q;
    logic       irq_q;

    int_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_int_edge_sync (
        .clk       (clk),
        .rst       (rst),
        .int_pin_i (int_pin),
        .intedg_i  (intedg),
        .edge_o    (w_int_edge)
    );

`ifdef INTCON_RB_CHANGE_EN
    logic [3:0] rb_latch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_latch_q <= 4'h0;
        end else if (cyc_en && portb_rd_en) begin
            rb_latch_q <= rb_hi;
        end
    end

    assign w_rb_set = (rb_hi != rb_latch_q);
`else
    logic w_rb_unused;
    assign w_rb_unused = ^{rb_hi, portb_rd_en};
    assign w_rb_set    = 1'b0;
`endif

    assign w_ack = (state_q == ST_REQ) && int_ack;

    // Hardware flag sets are applied after the write so a set beats a written 0.
    always_comb begin
        intcon_d   = intcon_q;
        t0_pend_d  = t0_pend_q;
        int_pend_d = int_pend_q;
        if (cyc_en) begin
            if (intcon_wr_en) begin
                intcon_d = intcon_reg_in;
            end
            if (tmr0if_set_en || t0_pend_q) begin
                intcon_d[T0IF_BIT] = 1'b1;
            end
            if (w_int_edge || int_pend_q) begin
                intcon_d[INTF_BIT] = 1'b1;
            end
            if (w_rb_set) begin
                intcon_d[RBIF_BIT] = 1'b1;
            end
            if (w_ack) begin
                intcon_d[GIE_BIT] = 1'b0;
            end else if (retfie) begin
                intcon_d[GIE_BIT] = 1'b1;
            end
            t0_pend_d  = 1'b0;
            int_pend_d = 1'b0;
        end else begin
            t0_pend_d  = t0_pend_q | tmr0if_set_en;
            int_pend_d = int_pend_q | w_int_edge;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intcon_q   <= 8'h00;
            t0_pend_q  <= 1'b0;
            int_pend_q <= 1'b0;
        end else begin
            intcon_q   <= intcon_d;
            t0_pend_q  <= t0_pend_d;
            int_pend_q <= int_pend_d;
        end
    end

    assign w_pend_q = intcon_pending(intcon_q, pir_pending);
    assign w_pend_d = intcon_pending(intcon_d, pir_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
        end else if (cyc_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (intcon_q[GIE_BIT] && w_pend_q) begin
                        state_q <= ST_REQ;
                        irq_q   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_q <= ST_SVC;
                        irq_q   <= 1'b0;
                    end else if (!(intcon_d[GIE_BIT] && w_pend_d)) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                ST_SVC: begin
                    if (retfie) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign intcon_reg_out = intcon_q;
    assign irq            = irq_q;
    assign vector_addr    = irq_q ? INT_VECTOR : 13'h0000;
    assign wake           = w_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_intcon_ctrl.sv
// ============================================================================
// Module      : tb_intcon_ctrl
// Description : Directed and randomized checks of intcon_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intcon_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc_en = 1'b0;
    logic        intcon_wr_en = 1'b0;
    logic [7:0]  intcon_reg_in = 8'h00;
    logic [7:0]  intcon_reg_out;
    logic        tmr0if_set_en = 1'b0;
    logic        int_pin = 1'b0;
    logic        intedg = 1'b0;
    logic [3:0]  rb_hi = 4'h0;
    logic        portb_rd_en = 1'b0;
    logic        pir_pending = 1'b0;
    logic        int_ack = 1'b0;
    logic        retfie = 1'b0;
    logic        irq;
    logic [12:0] vector_addr;
    logic        wake;

    int total = 0;
    int bad   = 0;

    intcon_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cyc_en         (cyc_en),
        .intcon_wr_en   (intcon_wr_en),
        .intcon_reg_in  (intcon_reg_in),
        .intcon_reg_out (intcon_reg_out),
        .tmr0if_set_en  (tmr0if_set_en),
        .int_pin        (int_pin),
        .intedg         (intedg),
        .rb_hi          (rb_hi),
        .portb_rd_en    (portb_rd_en),
        .pir_pending    (pir_pending),
        .int_ack        (int_ack),
        .retfie         (retfie),
        .irq            (irq),
        .vector_addr    (vector_addr),
        .wake           (wake)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cyc_en = 0; intcon_wr_en = 0; intcon_reg_in = 8'h00; tmr0if_set_en = 0;
        portb_rd_en = 0; int_ack = 0; retfie = 0;
    endtask

    // one instruction cycle with whatever strobes the caller has set up
    task automatic cyc();
        cyc_en = 1;
        tick();
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        int_pin = 0; intedg = 0; rb_hi = 4'h0; pir_pending = 0;
        rst = 1;
        repeat (2) tick();
        rst = 0;
        tick();
    endtask

    task automatic wr(input logic [7:0] d);
        intcon_wr_en = 1; intcon_reg_in = d;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (intcon_reg_out !== 8'h00) begin bad++; $display("FAIL reset_intcon got=%h exp=00", intcon_reg_out); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (wake !== 1'b0) begin bad++; $display("FAIL reset_wake got=%b exp=0", wake); end
        total++; if (vector_addr !== 13'h0) begin bad++; $display("FAIL reset_vec got=%h exp=0", vector_addr); end
    endtask

    task automatic test_t0_irq();
        do_reset();
        wr(8'hA0);
        tmr0if_set_en = 1; tick(); tmr0if_set_en = 0;
        repeat (3) tick();
        total++; if (intcon_reg_out !== 8'hA0) begin bad++; $display("FAIL t0_held got=%h exp=a0", intcon_reg_out); end
        cyc();
        total++; if (intcon_reg_out !== 8'hA4) begin bad++; $display("FAIL t0_set got=%h exp=a4", intcon_reg_out); end
        total++; if (irq !== 1'b0 || wake !== 1'b1) begin bad++; $display("FAIL t0_early irq=%b wake=%b exp irq=0 wake=1", irq, wake); end
        cyc();
        total++; if (irq !== 1'b1 || vector_addr !== 13'h004) begin bad++; $display("FAIL t0_irq irq=%b vec=%h exp 1/004", irq, vector_addr); end
        intcon_wr_en = 1; intcon_reg_in = 8'hA4; int_ack = 1; cyc();
        total++; if (intcon_reg_out !== 8'h24 || irq !== 1'b0) begin bad++; $display("FAIL ack got=%h irq=%b exp=24/0", intcon_reg_out, irq); end
        repeat (2) cyc();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL svc_quiet irq=%b exp=0", irq); end
        retfie = 1; cyc();
        total++; if (intcon_reg_out !== 8'hA4 || irq !== 1'b0) begin bad++; $display("FAIL retfie got=%h irq=%b exp=a4/0", intcon_reg_out, irq); end
        cyc();
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL reraise irq=%b exp=1", irq); end
        wr(8'hA0);
        cyc();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL withdraw irq=%b exp=0", irq); end
    endtask

    task automatic test_int_edge();
        do_reset();
        wr(8'h10);
        int_pin = 1; repeat (4) cyc();
        total++; if (intcon_reg_out !== 8'h10) begin bad++; $display("FAIL int_wrong_edge got=%h exp=10", intcon_reg_out); end
        int_pin = 0; repeat (4) cyc();
        total++; if (intcon_reg_out !== 8'h12) begin bad++; $display("FAIL int_fall got=%h exp=12", intcon_reg_out); end
        total++; if (wake !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL int_wake wake=%b irq=%b exp 1/0", wake, irq); end
        wr(8'h10);
        intedg = 1; repeat (3) cyc();
        intedg = 0; repeat (3) cyc();
        total++; if (intcon_reg_out !== 8'h10) begin bad++; $display("FAIL intedg_toggle got=%h exp=10", intcon_reg_out); end
        int_pin = 1; repeat (4) cyc();
        int_pin = 0; repeat (5) tick();
        total++; if (intcon_reg_out !== 8'h10) begin bad++; $display("FAIL int_held got=%h exp=10", intcon_reg_out); end
        cyc();
        total++; if (intcon_reg_out !== 8'h12) begin bad++; $display("FAIL int_pend got=%h exp=12", intcon_reg_out); end
    endtask

    task automatic test_write_collide();
        do_reset();
        intcon_wr_en = 1; intcon_reg_in = 8'hA0; tmr0if_set_en = 1; cyc();
        total++; if (intcon_reg_out !== 8'hA4) begin bad++; $display("FAIL wr_collide got=%h exp=a4", intcon_reg_out); end
    endtask

    task automatic test_rb_change();
        do_reset();
        rb_hi = 4'h5; portb_rd_en = 1; cyc();
        wr(8'h00);
        total++; if (intcon_reg_out !== 8'h00) begin bad++; $display("FAIL rb_match got=%h exp=00", intcon_reg_out); end
        rb_hi = 4'h7; cyc();
`ifdef INTCON_RB_CHANGE_EN
        total++; if (intcon_reg_out !== 8'h01) begin bad++; $display("FAIL rb_change got=%h exp=01", intcon_reg_out); end
`else
        total++; if (intcon_reg_out !== 8'h00) begin bad++; $display("FAIL rb_change got=%h exp=00", intcon_reg_out); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(8'hA0);
        tmr0if_set_en = 1; cyc();
        cyc();
        int_ack = 1; cyc();
        #2 rst = 1;
        #1;
        total++; if (intcon_reg_out !== 8'h00 || irq !== 1'b0) begin bad++; $display("FAIL async_rst got=%h irq=%b exp=00/0", intcon_reg_out, irq); end
        tick();
        rst = 0;
        repeat (6) cyc();
        total++; if (irq !== 1'b0 || intcon_reg_out !== 8'h00) begin bad++; $display("FAIL post_rst got=%h irq=%b exp=00/0", intcon_reg_out, irq); end
    endtask

    // Cycle-level model built directly from the flag/handshake rules.
    task automatic test_random();
        logic [7:0] m_reg, nxt;
        logic       m_t0p, m_req, m_svc, m_pend_now, m_pend_nxt, t0;
        int         errs;
        do_reset();
        m_reg = 8'h00; m_t0p = 0; m_req = 0; m_svc = 0; errs = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc_en        = ($urandom_range(0, 2) == 0);
            tmr0if_set_en = ($urandom_range(0, 9) == 0);
            intcon_wr_en  = ($urandom_range(0, 11) == 0);
            intcon_reg_in = 8'($urandom);
            if ($urandom_range(0, 15) == 0) pir_pending = ~pir_pending;
            intedg        = ($urandom_range(0, 7) == 0) ? ~intedg : intedg;
            int_ack       = irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            retfie        = ($urandom_range(0, 9) == 0);
            m_pend_now = (m_reg[5] & m_reg[2]) | (m_reg[4] & m_reg[1]) | (m_reg[3] & m_reg[0]) | (m_reg[6] & pir_pending);
            if (cyc_en) begin
                t0 = tmr0if_set_en | m_t0p;
                m_t0p = 0;
                nxt = intcon_wr_en ? intcon_reg_in : m_reg;
                if (t0) nxt[2] = 1;
                if (m_req && int_ack) nxt[7] = 0;
                else if (retfie) nxt[7] = 1;
                m_pend_nxt = (nxt[5] & nxt[2]) | (nxt[4] & nxt[1]) | (nxt[3] & nxt[0]) | (nxt[6] & pir_pending);
                if (m_req) begin
                    if (int_ack) begin m_req = 0; m_svc = 1; end
                    else if (!(nxt[7] && m_pend_nxt)) m_req = 0;
                end else if (m_svc) begin
                    if (retfie) m_svc = 0;
                end else if (m_reg[7] && m_pend_now) begin
                    m_req = 1;
                end
                m_reg = nxt;
            end else begin
                m_t0p = m_t0p | tmr0if_set_en;
            end
            tick();
            clear_inputs();
            m_pend_now = (m_reg[5] & m_reg[2]) | (m_reg[4] & m_reg[1]) | (m_reg[3] & m_reg[0]) | (m_reg[6] & pir_pending);
            total++;
            if (intcon_reg_out !== m_reg || irq !== m_req || wake !== m_pend_now ||
                vector_addr !== (m_req ? 13'h004 : 13'h000)) begin
                bad++;
                if (errs < 10) $display("FAIL rand[%0d] reg=%h irq=%b wake=%b vec=%h exp reg=%h irq=%b wake=%b",
                                        i, intcon_reg_out, irq, wake, vector_addr, m_reg, m_req, m_pend_now);
                errs++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_t0_irq();
        test_int_edge();
        test_write_collide();
        test_rb_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
